// File: rtl/mc_alu_ctrl.sv
// Multi-cycle MIPS control FSM: accepts one instruction per handshake, decodes it into
// ALU op/operand selects, resolves branches and overflow traps, and sequences MEM/WB.
module mc_alu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  ALUOPCtrl,
    output logic [1:0]  srcA_sel,
    output logic [1:0]  srcB_sel,
    input  logic        zero,
    input  logic        ovf,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ack,
    output logic        branch_taken,
    output logic        exc,
    output logic [1:0]  exc_code
);

    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_ADDU = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_SUBU = 5'd4;
    localparam logic [4:0] ALU_AND  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_XOR  = 5'd7;
    localparam logic [4:0] ALU_NOR  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] ALU_SLL  = 5'd11;
    localparam logic [4:0] ALU_SRL  = 5'd12;
    localparam logic [4:0] ALU_SRA  = 5'd13;
    localparam logic [4:0] ALU_LUI  = 5'd14;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_EXC    = 3'd5
    } state_t;

    // CL_TRAP marks signed add/sub, the only ops whose overflow raises an exception
    typedef enum logic [2:0] {
        CL_ALU  = 3'd0,
        CL_TRAP = 3'd1,
        CL_BEQ  = 3'd2,
        CL_BNE  = 3'd3,
        CL_LW   = 3'd4,
        CL_SW   = 3'd5
    } class_t;

    state_t      state_r, state_s;
    class_t      class_r, dec_cls_s;
    logic [5:0]  opcode_r, funct_r;
    logic [4:0]  aluop_r, dec_op_s;
    logic [1:0]  srca_r, srcb_r, dec_a_s, dec_b_s;
    logic        dst_r, dec_dst_s, dec_ok_s;
    logic [1:0]  code_s, exc_code_r;
    logic        taken_s;
    logic        reg_we_r, mem_to_reg_r, mem_rd_r, mem_wr_r, branch_taken_r, exc_r;
    // register/immediate fields are consumed by the datapath, not by the controller
    logic        unused_fields_s;

    assign unused_fields_s = ^instr[25:6];

    // Instruction latch: only opcode and funct steer the controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_r <= 6'd0;
            funct_r  <= 6'd0;
        end else if ((state_r == ST_FETCH) && instr_valid) begin
            opcode_r <= instr[31:26];
            funct_r  <= instr[5:0];
        end
    end

    // Opcode/funct decode into ALU op, operand selects and instruction class
    always_comb begin
        dec_ok_s  = 1'b1;
        dec_op_s  = ALU_ADDU;
        dec_a_s   = 2'd0;
        dec_b_s   = 2'd0;
        dec_dst_s = 1'b0;
        dec_cls_s = CL_ALU;
        case (opcode_r)
            6'h00: begin
                dec_dst_s = 1'b1;
                case (funct_r)
                    6'h20: begin dec_op_s = ALU_ADD;  dec_cls_s = CL_TRAP; end
                    6'h21: dec_op_s = ALU_ADDU;
                    6'h22: begin dec_op_s = ALU_SUB;  dec_cls_s = CL_TRAP; end
                    6'h23: dec_op_s = ALU_SUBU;
                    6'h24: dec_op_s = ALU_AND;
                    6'h25: dec_op_s = ALU_OR;
                    6'h26: dec_op_s = ALU_XOR;
                    6'h27: dec_op_s = ALU_NOR;
                    6'h2A: dec_op_s = ALU_SLT;
                    6'h2B: dec_op_s = ALU_SLTU;
                    6'h00: begin dec_op_s = ALU_SLL; dec_a_s = 2'd1; end
                    6'h02: begin dec_op_s = ALU_SRL; dec_a_s = 2'd1; end
                    6'h03: begin dec_op_s = ALU_SRA; dec_a_s = 2'd1; end
                    default: dec_ok_s = 1'b0;
                endcase
            end
            6'h08: begin dec_op_s = ALU_ADD;  dec_b_s = 2'd1; dec_cls_s = CL_TRAP; end
            6'h09: begin dec_op_s = ALU_ADDU; dec_b_s = 2'd1; end
            6'h0A: begin dec_op_s = ALU_SLT;  dec_b_s = 2'd1; end
            6'h0B: begin dec_op_s = ALU_SLTU; dec_b_s = 2'd1; end
            6'h0C: begin dec_op_s = ALU_AND;  dec_b_s = 2'd2; end
            6'h0D: begin dec_op_s = ALU_OR;   dec_b_s = 2'd2; end
            6'h0E: begin dec_op_s = ALU_XOR;  dec_b_s = 2'd2; end
            6'h0F: begin dec_op_s = ALU_LUI;  dec_b_s = 2'd2; end
            6'h23: begin dec_op_s = ALU_ADDU; dec_b_s = 2'd1; dec_cls_s = CL_LW; end
            6'h2B: begin dec_op_s = ALU_ADDU; dec_b_s = 2'd1; dec_cls_s = CL_SW; end
            6'h04: begin dec_op_s = ALU_XOR;  dec_cls_s = CL_BEQ; end
            6'h05: begin dec_op_s = ALU_XOR;  dec_cls_s = CL_BNE; end
            default: dec_ok_s = 1'b0;
        endcase
    end

    // Decoded controls are held from the cycle after DECODE until the next DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluop_r <= 5'd0;
            srca_r  <= 2'd0;
            srcb_r  <= 2'd0;
            dst_r   <= 1'b0;
            class_r <= CL_ALU;
        end else if ((state_r == ST_DECODE) && dec_ok_s) begin
            aluop_r <= dec_op_s;
            srca_r  <= dec_a_s;
            srcb_r  <= dec_b_s;
            dst_r   <= dec_dst_s;
            class_r <= dec_cls_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic, branch resolution and exception cause
    always_comb begin
        state_s = state_r;
        code_s  = exc_code_r;
        taken_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (instr_valid) state_s = ST_DECODE;
                else             state_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (dec_ok_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_EXC;
                    code_s  = 2'd2;
                end
            end
            ST_EXEC: begin
                case (class_r)
                    CL_TRAP: begin
                        if (ovf) begin
                            state_s = ST_EXC;
                            code_s  = 2'd1;
                        end else begin
                            state_s = ST_WB;
                        end
                    end
                    CL_BEQ: begin
                        state_s = ST_FETCH;
                        taken_s = zero;
                    end
                    CL_BNE: begin
                        state_s = ST_FETCH;
                        taken_s = ~zero;
                    end
                    CL_LW, CL_SW: state_s = ST_MEM;
                    default:      state_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (!mem_ack)               state_s = ST_MEM;
                else if (class_r == CL_LW)  state_s = ST_WB;
                else                        state_s = ST_FETCH;
            end
            ST_WB:   state_s = ST_FETCH;
            ST_EXC:  state_s = ST_FETCH;
            default: state_s = ST_FETCH;
        endcase
    end

    // Strobes and pulses registered from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we_r       <= 1'b0;
            mem_to_reg_r   <= 1'b0;
            mem_rd_r       <= 1'b0;
            mem_wr_r       <= 1'b0;
            branch_taken_r <= 1'b0;
            exc_r          <= 1'b0;
            exc_code_r     <= 2'd0;
        end else begin
            reg_we_r       <= (state_s == ST_WB);
            mem_to_reg_r   <= (state_s == ST_WB)  && (class_r == CL_LW);
            mem_rd_r       <= (state_s == ST_MEM) && (class_r == CL_LW);
            mem_wr_r       <= (state_s == ST_MEM) && (class_r == CL_SW);
            branch_taken_r <= taken_s;
            exc_r          <= (state_s == ST_EXC);
            exc_code_r     <= code_s;
        end
    end

    assign instr_ready  = (state_r == ST_FETCH);
    assign ALUOPCtrl    = aluop_r;
    assign srcA_sel     = srca_r;
    assign srcB_sel     = srcb_r;
    assign reg_dst      = dst_r;
    assign reg_we       = reg_we_r;
    assign mem_to_reg   = mem_to_reg_r;
    assign mem_rd       = mem_rd_r;
    assign mem_wr       = mem_wr_r;
    assign branch_taken = branch_taken_r;
    assign exc          = exc_r;
    assign exc_code     = exc_code_r;

endmodule

// File: tb/tb_mc_alu_ctrl.sv
// Randomized self-checking bench for mc_alu_ctrl against a table-driven timeline model.
module tb_mc_alu_ctrl;

    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_ADDU = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_SUBU = 5'd4;
    localparam logic [4:0] ALU_AND  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_XOR  = 5'd7;
    localparam logic [4:0] ALU_NOR  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] ALU_SLL  = 5'd11;
    localparam logic [4:0] ALU_SRL  = 5'd12;
    localparam logic [4:0] ALU_SRA  = 5'd13;
    localparam logic [4:0] ALU_LUI  = 5'd14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  ALUOPCtrl;
    logic [1:0]  srcA_sel, srcB_sel;
    logic        zero, ovf;
    logic        reg_we, reg_dst, mem_to_reg, mem_rd, mem_wr, mem_ack;
    logic        branch_taken, exc;
    logic [1:0]  exc_code;

    int n_cmp = 0;
    int n_bad = 0;

    // reference tables: op code 0 means "reserved"
    logic [4:0] r_op [64];
    logic [1:0] r_a  [64];
    logic [4:0] i_op [64];
    logic [1:0] i_b  [64];
    logic [1:0] model_code;

    mc_alu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .ALUOPCtrl(ALUOPCtrl), .srcA_sel(srcA_sel),
        .srcB_sel(srcB_sel), .zero(zero), .ovf(ovf), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ack(mem_ack), .branch_taken(branch_taken), .exc(exc), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] f);
        logic [31:0] w;
        w = $urandom;
        w[31:26] = 6'h00;
        w[5:0] = f;
        return w;
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op);
        logic [31:0] w;
        w = $urandom;
        w[31:26] = op;
        return w;
    endfunction

    // Issue one instruction at the current FETCH cycle and compare its whole timeline.
    task automatic run_instr(input logic [31:0] ins, input logic z, input logic o, input int n);
        logic [5:0] opc, fn;
        logic [4:0] e_op;
        logic [1:0] e_a, e_b;
        logic       e_dst, ok, is_r, trap, br, taken, lw, sw, e_m2r;
        int e_ready, e_we_at, e_exc_at, e_br_at, e_rd_n, e_wr_n;
        int we_cnt, we_at, rd_cnt, wr_cnt, br_cnt, br_at, exc_cnt, exc_at, ready_at;
        logic m2r_seen;
        logic [4:0] op2;
        logic [1:0] a2, b2;
        logic dst2;

        opc = ins[31:26];
        fn  = ins[5:0];
        is_r = (opc == 6'h00);
        if (is_r) begin
            e_op = r_op[fn]; e_a = r_a[fn]; e_b = 2'd0; e_dst = 1'b1;
        end else begin
            e_op = i_op[opc]; e_a = 2'd0; e_b = i_b[opc]; e_dst = 1'b0;
        end
        ok    = (e_op != 5'd0);
        trap  = ok && ((e_op == ALU_ADD) || (e_op == ALU_SUB));
        br    = !is_r && ((opc == 6'h04) || (opc == 6'h05));
        taken = (opc == 6'h04) ? z : !z;
        lw    = !is_r && (opc == 6'h23);
        sw    = !is_r && (opc == 6'h2B);

        e_we_at = -1; e_exc_at = -1; e_br_at = -1; e_rd_n = 0; e_wr_n = 0; e_m2r = 1'b0;
        if (!ok) begin
            e_exc_at = 2; e_ready = 3; model_code = 2'd2;
        end else if (trap && o) begin
            e_exc_at = 3; e_ready = 4; model_code = 2'd1;
        end else if (br) begin
            e_ready = 3;
            if (taken) e_br_at = 3;
        end else if (lw) begin
            e_rd_n = n; e_we_at = 3 + n; e_m2r = 1'b1; e_ready = 4 + n;
        end else if (sw) begin
            e_wr_n = n; e_ready = 3 + n;
        end else begin
            e_we_at = 3; e_ready = 4;
        end

        we_cnt = 0; we_at = -1; rd_cnt = 0; wr_cnt = 0; br_cnt = 0; br_at = -1;
        exc_cnt = 0; exc_at = -1; ready_at = -1; m2r_seen = 1'b0;
        op2 = 5'd0; a2 = 2'd0; b2 = 2'd0; dst2 = 1'b0;

        chk("ready0", 32'(instr_ready), 32'd1);
        instr = ins; instr_valid = 1'b1; zero = z; ovf = o; mem_ack = 1'b0;
        for (int k = 1; k <= 40 && ready_at < 0; k++) begin
            @(posedge clk); #1;
            if (k < e_ready) begin
                instr_valid = 1'($urandom);
                instr = $urandom;
            end else begin
                instr_valid = 1'b0;
            end
            if (ok && (lw || sw)) begin
                if (k == 2 + n)               mem_ack = 1'b1;
                else if (k < 3 || k > 2 + n)  mem_ack = 1'($urandom);
                else                          mem_ack = 1'b0;
            end else begin
                mem_ack = 1'($urandom);
            end
            if (reg_we) begin
                we_cnt++;
                if (we_at < 0) begin we_at = k; m2r_seen = mem_to_reg; end
            end
            if (mem_rd) rd_cnt++;
            if (mem_wr) wr_cnt++;
            if (branch_taken) begin br_cnt++; if (br_at < 0) br_at = k; end
            if (exc) begin exc_cnt++; if (exc_at < 0) exc_at = k; end
            if (k == 2) begin op2 = ALUOPCtrl; a2 = srcA_sel; b2 = srcB_sel; dst2 = reg_dst; end
            if (instr_ready) ready_at = k;
        end
        mem_ack = 1'b0;

        chk("ready_at", 32'(ready_at), 32'(e_ready));
        chk("we_at", 32'(we_at), 32'(e_we_at));
        chk("we_cnt", 32'(we_cnt), (e_we_at >= 0) ? 32'd1 : 32'd0);
        chk("mem_to_reg", 32'(m2r_seen), 32'(e_m2r));
        chk("rd_cnt", 32'(rd_cnt), 32'(e_rd_n));
        chk("wr_cnt", 32'(wr_cnt), 32'(e_wr_n));
        chk("br_at", 32'(br_at), 32'(e_br_at));
        chk("br_cnt", 32'(br_cnt), (e_br_at >= 0) ? 32'd1 : 32'd0);
        chk("exc_at", 32'(exc_at), 32'(e_exc_at));
        chk("exc_cnt", 32'(exc_cnt), (e_exc_at >= 0) ? 32'd1 : 32'd0);
        chk("exc_code", 32'(exc_code), 32'(model_code));
        if (ok) begin
            chk("aluop", 32'(op2), 32'(e_op));
            chk("srcA", 32'(a2), 32'(e_a));
            chk("srcB", 32'(b2), 32'(e_b));
            chk("reg_dst", 32'(dst2), 32'(e_dst));
            chk("aluop_hold", 32'(ALUOPCtrl), 32'(e_op));
        end
    endtask

    // lw stalled in MEM, then an asynchronous reset drops the request and discards it.
    task automatic reset_mid_mem();
        int we_cnt;
        chk("mr_ready0", 32'(instr_ready), 32'd1);
        instr = i_ins(6'h23); instr_valid = 1'b1; mem_ack = 1'b0; ovf = 1'b0;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mr_rd_on", 32'(mem_rd), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mr_rd_drop", 32'(mem_rd), 32'd0);
        chk("mr_we_low", 32'(reg_we), 32'd0);
        model_code = 2'd0;
        chk("mr_code", 32'(exc_code), 32'(model_code));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mr_ready", 32'(instr_ready), 32'd1);
        we_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            mem_ack = 1'($urandom);
            @(posedge clk); #1;
            if (reg_we || mem_rd) we_cnt++;
        end
        mem_ack = 1'b0;
        chk("mr_no_we", 32'(we_cnt), 32'd0);
    endtask

    logic [5:0] rf_list [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h01, 6'h3F};
    logic [5:0] io_list [17] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h02};

    initial begin
        for (int i = 0; i < 64; i++) begin
            r_op[i] = 5'd0; r_a[i] = 2'd0; i_op[i] = 5'd0; i_b[i] = 2'd0;
        end
        r_op[6'h20] = ALU_ADD;  r_op[6'h21] = ALU_ADDU; r_op[6'h22] = ALU_SUB;
        r_op[6'h23] = ALU_SUBU; r_op[6'h24] = ALU_AND;  r_op[6'h25] = ALU_OR;
        r_op[6'h26] = ALU_XOR;  r_op[6'h27] = ALU_NOR;  r_op[6'h2A] = ALU_SLT;
        r_op[6'h2B] = ALU_SLTU;
        r_op[6'h00] = ALU_SLL;  r_op[6'h02] = ALU_SRL;  r_op[6'h03] = ALU_SRA;
        r_a[6'h00] = 2'd1; r_a[6'h02] = 2'd1; r_a[6'h03] = 2'd1;
        i_op[6'h08] = ALU_ADD;  i_op[6'h09] = ALU_ADDU; i_op[6'h0A] = ALU_SLT;
        i_op[6'h0B] = ALU_SLTU; i_op[6'h0C] = ALU_AND;  i_op[6'h0D] = ALU_OR;
        i_op[6'h0E] = ALU_XOR;  i_op[6'h0F] = ALU_LUI;  i_op[6'h23] = ALU_ADDU;
        i_op[6'h2B] = ALU_ADDU; i_op[6'h04] = ALU_XOR;  i_op[6'h05] = ALU_XOR;
        i_b[6'h08] = 2'd1; i_b[6'h09] = 2'd1; i_b[6'h0A] = 2'd1; i_b[6'h0B] = 2'd1;
        i_b[6'h0C] = 2'd2; i_b[6'h0D] = 2'd2; i_b[6'h0E] = 2'd2; i_b[6'h0F] = 2'd2;
        i_b[6'h23] = 2'd1; i_b[6'h2B] = 2'd1;
        model_code = 2'd0;

        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0;
        zero = 1'b0; ovf = 1'b0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_aluop", 32'(ALUOPCtrl), 32'd0);
        chk("rst_srcA", 32'(srcA_sel), 32'd0);
        chk("rst_srcB", 32'(srcB_sel), 32'd0);
        chk("rst_strobes", {25'd0, reg_we, mem_rd, mem_wr, branch_taken, exc, reg_dst, mem_to_reg}, 32'd0);
        chk("rst_code", 32'(exc_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(r_ins(6'h20), 1'b0, 1'b0, 1);  // add
        run_instr(i_ins(6'h08), 1'b0, 1'b1, 1);  // addi overflow
        run_instr(r_ins(6'h22), 1'b0, 1'b1, 1);  // sub overflow
        run_instr(r_ins(6'h21), 1'b0, 1'b1, 1);  // addu ignores ovf
        run_instr(i_ins(6'h04), 1'b1, 1'b0, 1);  // beq taken
        run_instr(i_ins(6'h05), 1'b1, 1'b0, 1);  // bne not taken
        run_instr(i_ins(6'h23), 1'b0, 1'b0, 3);  // lw, ack after 3 cycles
        run_instr(i_ins(6'h2B), 1'b0, 1'b0, 1);  // sw, same-cycle ack
        run_instr(r_ins(6'h03), 1'b0, 1'b0, 1);  // sra
        run_instr(i_ins(6'h3F), 1'b0, 1'b0, 1);  // reserved opcode
        reset_mid_mem();

        for (int t = 0; t < 200; t++) begin
            logic [31:0] w;
            if ($urandom_range(0, 1) == 0) w = r_ins(rf_list[$urandom_range(0, 14)]);
            else                           w = i_ins(io_list[$urandom_range(0, 16)]);
            run_instr(w, 1'($urandom), 1'($urandom), int'($urandom_range(1, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
